// File: rtl/pow2_sched_pkg.sv
// Shared types and default sizing for the pow2 node scheduler.
package pow2_sched_pkg;
  localparam int BWIDTH_D = 4;
  localparam int UWIDTH_D = 2;
  localparam int NREQ_D   = 4;
  localparam int SUM_W_D  = 8;
  localparam int BEAT_W_D = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    RESULT = 2'd2
  } state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first requester after last_grant (wrapping) wins.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last_grant,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_id,
  output logic            any
);
  always_comb begin
    int c;
    logic [IDW-1:0] ci;
    grant    = '0;
    grant_id = '0;
    any      = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      c  = (int'(last_grant) + k) % NREQ;
      ci = IDW'(c);
      if (!any && req[ci]) begin
        any       = 1'b1;
        grant[ci] = 1'b1;
        grant_id  = ci;
      end
    end
  end
endmodule

// File: rtl/pow2_node_scheduler.sv
// Time-shares one combinational node among NREQ streaming requesters,
// accumulating node results per job with saturation.
module pow2_node_scheduler
  import pow2_sched_pkg::*;
#(
  parameter int BWIDTH = BWIDTH_D,
  parameter int UWIDTH = UWIDTH_D,
  parameter int NREQ   = NREQ_D,
  parameter int SUM_W  = SUM_W_D,
  parameter int BEAT_W = BEAT_W_D,
  localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*BWIDTH-1:0] req_x,
  input  logic [NREQ-1:0]        req_last,
  output logic [NREQ-1:0]        req_ready,
  output logic [BWIDTH-1:0]      node_x,
  input  logic [BWIDTH-1:0]      node_y,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [IDW-1:0]         res_id,
  output logic [SUM_W-1:0]       res_sum,
  output logic [BEAT_W-1:0]      res_beats,
  output logic                   res_sat
);
  if (UWIDTH != 2 || SUM_W < BWIDTH) begin : g_bad_params
    $error("pow2_node_scheduler: unsupported UWIDTH/SUM_W");
  end

  state_t            state, state_nxt;
  logic [IDW-1:0]    id, last_grant, arb_id;
  logic [NREQ-1:0]   grant_oh, arb_grant;
  logic              arb_any;
  logic [SUM_W-1:0]  sum;
  logic [BEAT_W-1:0] beats;
  logic              sat;
  logic [BWIDTH-1:0] sel_x;
  logic              sel_valid, sel_last, accept;
  logic [SUM_W:0]    sum_ext;
  logic [BEAT_W:0]   beats_ext;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req       (req_valid),
    .last_grant(last_grant),
    .grant     (arb_grant),
    .grant_id  (arb_id),
    .any       (arb_any)
  );

  always_comb begin
    sel_x     = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (id == IDW'(i)) begin
        sel_x     = req_x[i*BWIDTH +: BWIDTH];
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
      end
    end
  end

  // One extra bit on each adder exposes the saturation event directly.
  assign sum_ext   = {1'b0, sum} + {{(SUM_W+1-BWIDTH){1'b0}}, node_y};
  assign beats_ext = {1'b0, beats} + (BEAT_W+1)'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    node_x    = '0;
    accept    = 1'b0;
    res_valid = 1'b0;
    res_id    = '0;
    res_sum   = '0;
    res_beats = '0;
    res_sat   = 1'b0;
    case (state)
      IDLE: if (arb_any) state_nxt = STREAM;
      STREAM: begin
        req_ready = grant_oh;
        accept    = sel_valid;
        if (accept) node_x = sel_x;
        if (accept && sel_last) state_nxt = RESULT;
      end
      RESULT: begin
        res_valid = 1'b1;
        res_id    = id;
        res_sum   = sum;
        res_beats = beats;
        res_sat   = sat;
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id         <= '0;
      grant_oh   <= '0;
      last_grant <= IDW'(NREQ-1);
      sum        <= '0;
      beats      <= '0;
      sat        <= 1'b0;
    end else begin
      if (state == IDLE && arb_any) begin
        id       <= arb_id;
        grant_oh <= arb_grant;
        sum      <= '0;
        beats    <= '0;
        sat      <= 1'b0;
      end
      if (accept) begin
        sum   <= sum_ext[SUM_W]    ? '1 : sum_ext[SUM_W-1:0];
        beats <= beats_ext[BEAT_W] ? '1 : beats_ext[BEAT_W-1:0];
        if (sum_ext[SUM_W] || beats_ext[BEAT_W]) sat <= 1'b1;
      end
      if (state == RESULT && res_ready) last_grant <= id;
    end
  end
endmodule

// File: tb/tb_pow2_node_scheduler.sv
// Randomized bench for pow2_node_scheduler against a job-level reference model.
module tb_pow2_node_scheduler;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = '0, req_last = '0, req_ready;
  logic [15:0] req_x = '0;
  logic [3:0]  node_x, node_y = '0;
  logic        res_valid, res_ready = 1'b0;
  logic [1:0]  res_id;
  logic [7:0]  res_sum, res_beats;
  logic        res_sat;

  int total = 0, bad = 0;
  int ys[64];
  int m_last = 3;

  always #5 clk = ~clk;

  pow2_node_scheduler dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_x(req_x),
    .req_last(req_last), .req_ready(req_ready), .node_x(node_x),
    .node_y(node_y), .res_valid(res_valid), .res_ready(res_ready),
    .res_id(res_id), .res_sum(res_sum), .res_beats(res_beats), .res_sat(res_sat)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  function automatic int rr_pick(input int last, input logic [3:0] m);
    for (int k = 1; k <= 4; k++)
      if (m[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  function automatic int total_y(input int n);
    int s = 0;
    for (int i = 0; i < n; i++) s += ys[i];
    return s;
  endfunction

  function automatic int exp_sum(input int n);
    return (total_y(n) > 255) ? 255 : total_y(n);
  endfunction

  function automatic int exp_sat(input int n);
    return (total_y(n) > 255 || n > 255) ? 1 : 0;
  endfunction

  // Runs one job from IDLE (called on a falling edge) and reports what the DUT returned.
  task automatic drive_job(input logic [3:0] vmask, input int n, input int stall_at,
                           input int stall_len, input int bp,
                           output int gid, output int gsum, output int gbeats,
                           output int gsat, output int xerr, output int herr);
    int t;
    int id;
    gid = -1; gsum = -1; gbeats = -1; gsat = -1; xerr = 0; herr = 0; id = 0;
    req_valid = vmask; req_last = '0; res_ready = 1'b0;
    t = 0;
    while (req_ready == 4'b0 && t < 20) begin @(negedge clk); t++; end
    if (req_ready == 4'b0) begin
      $display("FAIL grant_timeout: no req_ready after %0d cycles", t);
      req_valid = '0;
      return;
    end
    if ($countones(req_ready) != 1) xerr++;
    for (int i = 0; i < 4; i++) if (req_ready[i]) id = i;
    for (int b = 0; b < n; b++) begin
      if (b == stall_at) begin
        repeat (stall_len) begin
          req_valid = vmask & ~(4'b1 << id);
          req_x = 16'($urandom); node_y = 4'($urandom); req_last = 4'($urandom);
          #1;
          if (node_x !== 4'b0) xerr++;
          @(negedge clk);
        end
      end
      req_valid = vmask | (4'b1 << id);
      req_x = 16'($urandom);
      req_last = (4'($urandom) & ~(4'b1 << id)) | ((b == n-1) ? (4'b1 << id) : 4'b0);
      node_y = 4'(ys[b]);
      #1;
      if (node_x !== req_x[id*4 +: 4]) xerr++;
      if (res_valid !== 1'b0) xerr++;
      @(negedge clk);
    end
    req_valid = vmask; req_last = '0; node_y = 4'($urandom);
    if (res_valid !== 1'b1) begin
      $display("FAIL result_timeout: res_valid=%b one cycle after last beat", res_valid);
      req_valid = '0;
      return;
    end
    gid = res_id; gsum = res_sum; gbeats = res_beats; gsat = res_sat;
    repeat (bp) begin
      @(negedge clk);
      if (res_valid !== 1'b1 || res_id != gid || res_sum != gsum ||
          res_beats != gbeats || res_sat != gsat) herr++;
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    if (res_valid !== 1'b0 || res_sum !== 8'b0 || res_beats !== 8'b0) herr++;
    req_valid = '0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (4) begin
      req_valid = 4'($urandom); req_x = 16'($urandom); req_last = 4'($urandom);
      node_y = 4'($urandom); res_ready = 1'($urandom);
      @(posedge clk); #1;
      total++;
      if ({req_ready, node_x, res_valid, res_id, res_sum, res_beats, res_sat} !== 28'b0) begin
        bad++;
        $display("FAIL reset_outputs: got=%h want=0",
                 {req_ready, node_x, res_valid, res_id, res_sum, res_beats, res_sat});
      end
    end
    @(negedge clk);
    rst_n = 1'b1; req_valid = 4'b0001; req_last = '0; res_ready = 1'b0;
    #1;
    total++;
    if (req_ready !== 4'b0000) begin bad++; $display("FAIL ready_idle: got=%b want=0000", req_ready); end
    @(negedge clk);
    total++;
    if (req_ready !== 4'b0001) begin bad++; $display("FAIL first_grant: got=%b want=0001", req_ready); end
    rst_n = 1'b0; req_valid = '0;
    #1;
    total++;
    if (req_ready !== 4'b0 || res_valid !== 1'b0) begin
      bad++; $display("FAIL async_reset: ready=%b res_valid=%b want 0", req_ready, res_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_last = 3;
  endtask

  task automatic test_single;
    int gid, gsum, gbeats, gsat, xerr, herr;
    ys[0] = 3; ys[1] = 5; ys[2] = 2;
    drive_job(4'b0001, 3, -1, 0, 0, gid, gsum, gbeats, gsat, xerr, herr);
    total++;
    if (gid != 0 || gsum != 10 || gbeats != 3 || gsat != 0) begin
      bad++;
      $display("FAIL single_job: id=%0d sum=%0d beats=%0d sat=%0d want 0/10/3/0", gid, gsum, gbeats, gsat);
    end
    total++;
    if (xerr != 0) begin bad++; $display("FAIL single_node_x: errors=%0d want 0", xerr); end
    m_last = 0;
  endtask

  task automatic test_fairness;
    int gid, gsum, gbeats, gsat, xerr, herr;
    int ord[4];
    ord = '{2, 3, 0, 1};
    ys[0] = $urandom_range(0, 15);
    drive_job(4'b0010, 1, -1, 0, 0, gid, gsum, gbeats, gsat, xerr, herr);
    total++;
    if (gid != rr_pick(m_last, 4'b0010)) begin bad++; $display("FAIL fair_setup: id=%0d want 1", gid); end
    m_last = 1;
    for (int k = 0; k < 4; k++) begin
      ys[0] = $urandom_range(0, 15);
      drive_job(4'b1111, 1, -1, 0, 0, gid, gsum, gbeats, gsat, xerr, herr);
      total++;
      if (gid != ord[k] || gid != rr_pick(m_last, 4'b1111) || gsum != ys[0] || gbeats != 1) begin
        bad++;
        $display("FAIL fairness[%0d]: id=%0d sum=%0d beats=%0d want id=%0d sum=%0d beats=1",
                 k, gid, gsum, gbeats, ord[k], ys[0]);
      end
      m_last = ord[k];
    end
  endtask

  task automatic test_saturation;
    int gid, gsum, gbeats, gsat, xerr, herr, eid;
    for (int i = 0; i < 20; i++) ys[i] = 15;
    eid = rr_pick(m_last, 4'b1000);
    drive_job(4'b1000, 20, -1, 0, 0, gid, gsum, gbeats, gsat, xerr, herr);
    total++;
    if (gid != eid || gsum != 255 || gbeats != 20 || gsat != 1) begin
      bad++;
      $display("FAIL saturation: id=%0d sum=%0d beats=%0d sat=%0d want %0d/255/20/1", gid, gsum, gbeats, gsat, eid);
    end
    m_last = eid;
  endtask

  task automatic test_stall;
    int gid, gsum, gbeats, gsat, xerr, herr, eid;
    for (int i = 0; i < 4; i++) ys[i] = $urandom_range(0, 15);
    eid = rr_pick(m_last, 4'b0110);
    drive_job(4'b0110, 4, 2, 2, 3, gid, gsum, gbeats, gsat, xerr, herr);
    total++;
    if (gid != eid || gsum != exp_sum(4) || gbeats != 4 || gsat != 0) begin
      bad++;
      $display("FAIL stall_result: id=%0d sum=%0d beats=%0d want %0d/%0d/4", gid, gsum, gbeats, eid, exp_sum(4));
    end
    total++;
    if (xerr != 0) begin bad++; $display("FAIL stall_node_x: errors=%0d want 0", xerr); end
    total++;
    if (herr != 0) begin bad++; $display("FAIL backpressure_hold: errors=%0d want 0", herr); end
    m_last = eid;
  endtask

  task automatic test_reset_mid;
    int gid, gsum, gbeats, gsat, xerr, herr, t, seen;
    req_valid = 4'b0100; req_last = '0; t = 0;
    while (req_ready == 4'b0 && t < 20) begin @(negedge clk); t++; end
    total++;
    if (req_ready !== 4'b0100) begin bad++; $display("FAIL mid_grant: got=%b want=0100", req_ready); end
    repeat (2) begin node_y = 4'($urandom_range(1, 15)); @(negedge clk); end
    rst_n = 1'b0; seen = 0;
    repeat (2) begin @(negedge clk); if (res_valid !== 1'b0 || req_ready !== 4'b0) seen++; end
    rst_n = 1'b1; req_valid = '0;
    repeat (2) begin @(negedge clk); if (res_valid !== 1'b0) seen++; end
    total++;
    if (seen != 0) begin bad++; $display("FAIL mid_reset_discard: res_valid/ready seen %0d times want 0", seen); end
    m_last = 3;
    ys[0] = $urandom_range(0, 15); ys[1] = $urandom_range(0, 15);
    drive_job(4'b0100, 2, -1, 0, 0, gid, gsum, gbeats, gsat, xerr, herr);
    total++;
    if (gid != 2 || gsum != exp_sum(2) || gbeats != 2 || gsat != 0) begin
      bad++;
      $display("FAIL post_reset_job: id=%0d sum=%0d beats=%0d want 2/%0d/2", gid, gsum, gbeats, exp_sum(2));
    end
    m_last = 2;
  endtask

  task automatic test_random;
    int gid, gsum, gbeats, gsat, xerr, herr, eid, n, sa;
    logic [3:0] vm;
    for (int j = 0; j < 10; j++) begin
      vm = 4'($urandom_range(1, 15));
      n  = $urandom_range(1, 24);
      for (int i = 0; i < n; i++) ys[i] = $urandom_range(0, 15);
      sa = ($urandom_range(0, 1) == 1) ? $urandom_range(0, n-1) : -1;
      eid = rr_pick(m_last, vm);
      drive_job(vm, n, sa, $urandom_range(1, 3), $urandom_range(0, 2),
                gid, gsum, gbeats, gsat, xerr, herr);
      total++;
      if (gid != eid || gsum != exp_sum(n) || gbeats != n || gsat != exp_sat(n) ||
          xerr != 0 || herr != 0) begin
        bad++;
        $display("FAIL random[%0d]: id=%0d sum=%0d beats=%0d sat=%0d xerr=%0d herr=%0d want %0d/%0d/%0d/%0d/0/0",
                 j, gid, gsum, gbeats, gsat, xerr, herr, eid, exp_sum(n), n, exp_sat(n));
      end
      m_last = eid;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_saturation();
    test_stall();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
